// File: rtl/cache_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_wb_ctrl
// Brief    : Direct-mapped write-back / write-allocate data cache with burst
//            line refill and writeback, whole-cache flush and hit/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
module cache_wb_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int INDEX_W    = 11,
    parameter int LINE_WORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [DATA_W/8-1:0] cpu_be,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_ready,
    input  logic                flush,
    output logic                flush_done,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt
);

    localparam int c_BE_W      = DATA_W / 8;
    localparam int c_BOFF_W    = $clog2(c_BE_W);
    localparam int c_WSEL_BITS = $clog2(LINE_WORDS);
    localparam int c_WSEL_W    = (c_WSEL_BITS > 0) ? c_WSEL_BITS : 1;
    localparam int c_OFF_W     = c_WSEL_BITS + c_BOFF_W;
    localparam int c_TAG_W     = ADDR_W - INDEX_W - c_OFF_W;
    localparam int c_LINES     = 1 << INDEX_W;
    localparam int c_DIDX_W    = INDEX_W + c_WSEL_BITS;

    localparam logic [2:0] c_ST_IDLE       = 3'd0;
    localparam logic [2:0] c_ST_LOOKUP     = 3'd1;
    localparam logic [2:0] c_ST_WB         = 3'd2;
    localparam logic [2:0] c_ST_REFILL     = 3'd3;
    localparam logic [2:0] c_ST_RESPOND    = 3'd4;
    localparam logic [2:0] c_ST_FLUSH_SCAN = 3'd5;
    localparam logic [2:0] c_ST_FLUSH_WB   = 3'd6;

    logic [2:0]          r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [c_BE_W-1:0]   r_be;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_WSEL_W-1:0] r_beat;
    logic [INDEX_W-1:0]  r_flush_idx;
    logic [c_LINES-1:0]  r_valid;
    logic [c_LINES-1:0]  r_dirty;

    logic [c_TAG_W-1:0]  r_tag_mem  [c_LINES];
    logic [DATA_W-1:0]   r_data_mem [c_LINES*LINE_WORDS];

    logic [c_TAG_W-1:0]  w_tag;
    logic [INDEX_W-1:0]  w_index;
    logic [c_WSEL_W-1:0] w_word;
    logic                w_hit;
    logic                w_ack;
    logic                w_beat_last;
    logic [c_WSEL_W-1:0] w_beat_next;
    logic [c_WSEL_W-1:0] w_wb_rd_beat;
    logic [INDEX_W-1:0]  w_wb_line;
    logic [c_DIDX_W-1:0] w_cpu_didx;
    logic [DATA_W-1:0]   w_cpu_word;
    logic [DATA_W-1:0]   w_wb_rdata;
    logic [ADDR_W-1:0]   w_wb_base;
    logic [ADDR_W-1:0]   w_rf_base;
    logic [ADDR_W-1:0]   w_next_ofs;
    logic                w_dwe;
    logic [c_DIDX_W-1:0] w_didx;
    logic [DATA_W-1:0]   w_dwdata;
    logic [c_BE_W-1:0]   w_dbe;
    logic                w_tag_we;
    logic                w_unused;

    assign w_tag   = r_addr[ADDR_W-1 -: c_TAG_W];
    assign w_index = r_addr[c_OFF_W +: INDEX_W];

    generate
        if (c_WSEL_BITS > 0) begin : g_word_sel
            assign w_word = r_addr[c_BOFF_W +: c_WSEL_W];
        end else begin : g_single_word
            assign w_word = '0;
        end
    endgenerate

    // Byte-offset bits of the request address carry no information here.
    assign w_unused = ^r_addr;

    assign w_hit        = r_valid[w_index] && (r_tag_mem[w_index] == w_tag);
    assign w_ack        = mem_req && mem_ack;
    assign w_beat_last  = (r_beat == c_WSEL_W'(LINE_WORDS - 1));
    assign w_beat_next  = r_beat + c_WSEL_W'(1);
    assign w_next_ofs   = ADDR_W'(w_beat_next) << c_BOFF_W;
    assign w_cpu_didx   = c_DIDX_W'(w_index) * c_DIDX_W'(LINE_WORDS) + c_DIDX_W'(w_word);
    assign w_cpu_word   = r_data_mem[w_cpu_didx];

    // Writeback source: flush walks its own index, a miss evicts the request's line.
    assign w_wb_line    = (r_state == c_ST_FLUSH_SCAN || r_state == c_ST_FLUSH_WB) ? r_flush_idx : w_index;
    assign w_wb_rd_beat = (r_state == c_ST_WB || r_state == c_ST_FLUSH_WB) ? w_beat_next : '0;
    assign w_wb_rdata   = r_data_mem[c_DIDX_W'(w_wb_line) * c_DIDX_W'(LINE_WORDS) + c_DIDX_W'(w_wb_rd_beat)];
    assign w_wb_base    = {r_tag_mem[w_wb_line], w_wb_line, {c_OFF_W{1'b0}}};
    assign w_rf_base    = {w_tag, w_index, {c_OFF_W{1'b0}}};
    assign w_tag_we     = (r_state == c_ST_REFILL) && w_ack && w_beat_last;

    always_comb begin
        w_dwe    = 1'b0;
        w_didx   = w_cpu_didx;
        w_dwdata = r_wdata;
        w_dbe    = r_be;
        case (r_state)
            c_ST_REFILL: begin
                if (w_ack) begin
                    w_dwe    = 1'b1;
                    w_didx   = c_DIDX_W'(w_index) * c_DIDX_W'(LINE_WORDS) + c_DIDX_W'(r_beat);
                    w_dwdata = mem_rdata;
                    w_dbe    = '1;
                end
            end
            c_ST_LOOKUP:  w_dwe = w_hit && r_we;
            c_ST_RESPOND: w_dwe = r_we;
            default:      w_dwe = 1'b0;
        endcase
    end

    // Tag and data storage carry no reset so they can map onto RAM.
    always_ff @(posedge clk) begin
        if (w_dwe) begin
            for (int b = 0; b < c_BE_W; b++) begin
                if (w_dbe[b]) begin
                    r_data_mem[w_didx][8*b +: 8] <= w_dwdata[8*b +: 8];
                end
            end
        end
        if (w_tag_we) begin
            r_tag_mem[w_index] <= w_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_beat      <= '0;
            r_flush_idx <= '0;
            r_valid     <= '0;
            r_dirty     <= '0;
            cpu_rdata   <= '0;
            cpu_ready   <= 1'b0;
            flush_done  <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
        end else begin
            cpu_ready  <= 1'b0;
            flush_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    // Skip the completion cycle so a still-held request or flush is not re-taken.
                    if (!cpu_ready && !flush_done) begin
                        if (flush) begin
                            r_flush_idx <= '0;
                            r_state     <= c_ST_FLUSH_SCAN;
                        end else if (cpu_req) begin
                            r_addr  <= cpu_addr;
                            r_we    <= cpu_we;
                            r_be    <= cpu_be;
                            r_wdata <= cpu_wdata;
                            r_state <= c_ST_LOOKUP;
                        end
                    end
                end
                c_ST_LOOKUP: begin
                    if (w_hit) begin
                        cpu_ready <= 1'b1;
                        cpu_rdata <= w_cpu_word;
                        if (r_we) r_dirty[w_index] <= 1'b1;
                        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
                        r_state <= c_ST_IDLE;
                    end else begin
                        if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
                        r_beat  <= '0;
                        mem_req <= 1'b1;
                        if (r_valid[w_index] && r_dirty[w_index]) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= w_wb_base;
                            mem_wdata <= w_wb_rdata;
                            r_state   <= c_ST_WB;
                        end else begin
                            mem_we   <= 1'b0;
                            mem_addr <= w_rf_base;
                            r_state  <= c_ST_REFILL;
                        end
                    end
                end
                c_ST_WB: begin
                    if (w_ack) begin
                        if (w_beat_last) begin
                            r_beat   <= '0;
                            mem_we   <= 1'b0;
                            mem_addr <= w_rf_base;
                            r_state  <= c_ST_REFILL;
                        end else begin
                            r_beat    <= w_beat_next;
                            mem_addr  <= w_wb_base | w_next_ofs;
                            mem_wdata <= w_wb_rdata;
                        end
                    end
                end
                c_ST_REFILL: begin
                    if (w_ack) begin
                        if (w_beat_last) begin
                            mem_req          <= 1'b0;
                            r_valid[w_index] <= 1'b1;
                            r_dirty[w_index] <= 1'b0;
                            r_state          <= c_ST_RESPOND;
                        end else begin
                            r_beat   <= w_beat_next;
                            mem_addr <= w_rf_base | w_next_ofs;
                        end
                    end
                end
                c_ST_RESPOND: begin
                    cpu_ready <= 1'b1;
                    cpu_rdata <= w_cpu_word;
                    if (r_we) r_dirty[w_index] <= 1'b1;
                    r_state <= c_ST_IDLE;
                end
                c_ST_FLUSH_SCAN: begin
                    if (r_valid[r_flush_idx] && r_dirty[r_flush_idx]) begin
                        r_beat    <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= w_wb_base;
                        mem_wdata <= w_wb_rdata;
                        r_state   <= c_ST_FLUSH_WB;
                    end else if (r_flush_idx == '1) begin
                        flush_done <= 1'b1;
                        r_state    <= c_ST_IDLE;
                    end else begin
                        r_flush_idx <= r_flush_idx + INDEX_W'(1);
                    end
                end
                c_ST_FLUSH_WB: begin
                    if (w_ack) begin
                        if (w_beat_last) begin
                            mem_req              <= 1'b0;
                            mem_we               <= 1'b0;
                            r_dirty[r_flush_idx] <= 1'b0;
                            if (r_flush_idx == '1) begin
                                flush_done <= 1'b1;
                                r_state    <= c_ST_IDLE;
                            end else begin
                                r_flush_idx <= r_flush_idx + INDEX_W'(1);
                                r_state     <= c_ST_FLUSH_SCAN;
                            end
                        end else begin
                            r_beat    <= w_beat_next;
                            mem_addr  <= w_wb_base | w_next_ofs;
                            mem_wdata <= w_wb_rdata;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
